// File: rtl/joy_dir_filter.sv
// joy_dir_filter: per-channel joystick conditioning between the hps_io
// joystick words and the core input mapping. Each channel is debounced,
// optionally SOCD-cleaned, restricted to 8-way / 4-way-last / 4-way-first
// and given autofire on its fire button.
module joy_dir_filter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DB_TICKS = 4,
  parameter int unsigned AF_DIV   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [1:0]            mode,
  input  logic                  socd,
  input  logic [NUM_CH-1:0]     af_en,
  input  logic [4*NUM_CH-1:0]   dir_in,
  input  logic [NUM_CH-1:0]     fire_in,
  output logic [4*NUM_CH-1:0]   dir_out,
  output logic [NUM_CH-1:0]     fire_out,
  output logic [NUM_CH-1:0]     active
);

  typedef enum logic [1:0] {
    MODE_PASS8     = 2'd0,
    MODE_LAST4     = 2'd1,
    MODE_FIRST4    = 2'd2,
    MODE_LAST4_ALT = 2'd3
  } mode_e;

  localparam logic [3:0] DB_LIM  = DB_TICKS[3:0];
  localparam logic [7:0] AF_LAST = 8'(AF_DIV - 1);

  // Per-channel input bundle: [4:1] = {up,down,left,right}, [0] = fire.
  logic [NUM_CH-1:0][4:0]       in_q;
  logic [NUM_CH-1:0][4:0]       deb_q, deb_d, deb_eff;
  logic [NUM_CH-1:0][4:0][3:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0][3:0]       cl_w;
  logic [NUM_CH-1:0][3:0]       new_w;
  logic [NUM_CH-1:0][3:0]       cl_prev_q;
  logic [NUM_CH-1:0][3:0]       mask_q, mask_d;
  logic [NUM_CH-1:0][7:0]       af_cnt_q, af_cnt_d;
  logic [NUM_CH-1:0]            af_ph_q, af_ph_d;
  logic [NUM_CH-1:0]            fire_prev_q;
  logic [4*NUM_CH-1:0]          dir_q, dir_d;
  logic [NUM_CH-1:0]            fire_q, fire_d;
  logic [NUM_CH-1:0]            active_q, active_d;
  mode_e                        mode_s;

  assign mode_s = mode_e'(mode);

  // Highest-priority set bit: up > down > left > right.
  function automatic logic [3:0] pick_hi(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  // Stage 0: register raw inputs every clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        in_q[c] <= {dir_in[4*c +: 4], fire_in[c]};
      end
    end
  end

  // Debounce: accept a change after DB_TICKS consecutive differing ce ticks.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (DB_TICKS == 0) begin
      deb_d = in_q;
    end else if (ce) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned b = 0; b < 5; b++) begin
          if (in_q[c][b] == deb_q[c][b]) begin
            cnt_d[c][b] = '0;
          end else if (cnt_q[c][b] + 4'd1 == DB_LIM) begin
            deb_d[c][b] = in_q[c][b];
            cnt_d[c][b] = '0;
          end else begin
            cnt_d[c][b] = cnt_q[c][b] + 4'd1;
          end
        end
      end
    end
  end

  // With debounce bypassed the stage-0 register feeds the filter directly,
  // keeping the input-to-output latency at two clocks.
  assign deb_eff = (DB_TICKS == 0) ? in_q : deb_q;

  // SOCD cleaning, direction mask selection and registered outputs.
  // dir_out uses the mask being loaded this clk so a new selection is
  // visible in the same cycle the mask register updates.
  always_comb begin
    cl_w     = '0;
    new_w    = '0;
    mask_d   = mask_q;
    dir_d    = '0;
    active_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cl_w[c] = deb_eff[c][4:1];
      if (socd && cl_w[c][3] && cl_w[c][2]) cl_w[c][3:2] = 2'b00;
      if (socd && cl_w[c][1] && cl_w[c][0]) cl_w[c][1:0] = 2'b00;
      new_w[c] = cl_w[c] & ~cl_prev_q[c];
      case (mode_s)
        MODE_PASS8: begin
          mask_d[c] = '0;
        end
        MODE_FIRST4: begin
          if ((cl_w[c] & mask_q[c]) == '0) mask_d[c] = pick_hi(cl_w[c]);
        end
        default: begin
          if (new_w[c] != '0) begin
            mask_d[c] = pick_hi(new_w[c]);
          end else if ((cl_w[c] & mask_q[c]) == '0) begin
            mask_d[c] = pick_hi(cl_w[c]);
          end
        end
      endcase
      if (mode_s == MODE_PASS8) dir_d[4*c +: 4] = cl_w[c];
      else                      dir_d[4*c +: 4] = cl_w[c] & mask_d[c];
      active_d[c] = |dir_d[4*c +: 4];
    end
  end

  // Autofire: square wave of AF_DIV ce ticks per half-period while fire held.
  always_comb begin
    af_cnt_d = af_cnt_q;
    af_ph_d  = af_ph_q;
    fire_d   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!deb_eff[c][0] || !fire_prev_q[c]) begin
        af_cnt_d[c] = '0;
        af_ph_d[c]  = 1'b1;
      end else if (af_en[c] && ce) begin
        if (af_cnt_q[c] == AF_LAST) begin
          af_cnt_d[c] = '0;
          af_ph_d[c]  = ~af_ph_q[c];
        end else begin
          af_cnt_d[c] = af_cnt_q[c] + 8'd1;
        end
      end
      fire_d[c] = deb_eff[c][0] & (af_en[c] ? af_ph_d[c] : 1'b1);
    end
  end

  // Filter state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q       <= '0;
      cnt_q       <= '0;
      cl_prev_q   <= '0;
      mask_q      <= '0;
      af_cnt_q    <= '0;
      af_ph_q     <= '1;
      fire_prev_q <= '0;
      dir_q       <= '0;
      fire_q      <= '0;
      active_q    <= '0;
    end else begin
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      cl_prev_q <= cl_w;
      mask_q    <= mask_d;
      af_cnt_q  <= af_cnt_d;
      af_ph_q   <= af_ph_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        fire_prev_q[c] <= deb_eff[c][0];
      end
      dir_q     <= dir_d;
      fire_q    <= fire_d;
      active_q  <= active_d;
    end
  end

  assign dir_out  = dir_q;
  assign fire_out = fire_q;
  assign active   = active_q;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: two instances (debounce bypassed and 4-tick
// debounce) share stimulus; directed scenarios plus a randomized run
// compared against a behavioural model of the filter rules.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       socd = 1'b0;
  logic [1:0] af_en = 2'b00;
  logic [7:0] dir_in = 8'h00;
  logic [1:0] fire_in = 2'b00;

  logic [7:0] dout0, dout4;
  logic [1:0] fout0, fout4, act0, act4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(.NUM_CH(2), .DB_TICKS(0), .AF_DIV(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode), .socd(socd),
    .af_en(af_en), .dir_in(dir_in), .fire_in(fire_in),
    .dir_out(dout0), .fire_out(fout0), .active(act0)
  );

  joy_dir_filter #(.NUM_CH(2), .DB_TICKS(4), .AF_DIV(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode), .socd(socd),
    .af_en(af_en), .dir_in(dir_in), .fire_in(fire_in),
    .dir_out(dout4), .fire_out(fout4), .active(act4)
  );

  // ---------------- behavioural model ----------------
  // Directions held as priority index p (0=up,1=down,2=left,3=right),
  // stored at bit 3-p. owner = currently selected direction or -1.
  localparam int AF = 8;
  int         DBV [2] = '{0, 4};
  bit [4:0]   m_inq  [2][2];
  bit [4:0]   m_deb  [2][2];
  int         m_cnt  [2][2][5];
  int         m_owner[2][2];
  bit [3:0]   m_prev [2][2];
  int         m_afc  [2][2];
  bit         m_ph   [2][2];
  bit         m_pf   [2][2];
  bit [7:0]   exp_dir [2];
  bit [1:0]   exp_fire[2];
  bit [1:0]   exp_act [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        exp_dir[k] = '0; exp_fire[k] = '0; exp_act[k] = '0;
        for (int c = 0; c < 2; c++) begin
          m_inq[k][c] = '0; m_deb[k][c] = '0; m_owner[k][c] = -1;
          m_prev[k][c] = '0; m_afc[k][c] = 0; m_ph[k][c] = 1'b1; m_pf[k][c] = 1'b0;
          for (int b = 0; b < 5; b++) m_cnt[k][c][b] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 2; c++) begin
          bit [4:0] eff;
          bit [3:0] cl;
          bit [3:0] o;
          int m, fresh, held;
          bit f;
          eff = (DBV[k] == 0) ? m_inq[k][c] : m_deb[k][c];
          if (DBV[k] == 0) m_deb[k][c] = m_inq[k][c];
          else if (ce) begin
            for (int b = 0; b < 5; b++) begin
              if (m_inq[k][c][b] != m_deb[k][c][b]) begin
                m_cnt[k][c][b]++;
                if (m_cnt[k][c][b] == DBV[k]) begin
                  m_deb[k][c][b] = m_inq[k][c][b];
                  m_cnt[k][c][b] = 0;
                end
              end else m_cnt[k][c][b] = 0;
            end
          end
          cl = eff[4:1];
          if (socd && cl[3] && cl[2]) cl[3:2] = 2'b00;
          if (socd && cl[1] && cl[0]) cl[1:0] = 2'b00;
          m = (mode == 2'd3) ? 1 : int'(mode);
          fresh = -1; held = -1;
          for (int p = 0; p < 4; p++) begin
            if (held < 0 && cl[3-p]) held = p;
            if (fresh < 0 && cl[3-p] && !m_prev[k][c][3-p]) fresh = p;
          end
          if (m == 0) m_owner[k][c] = -1;
          else if (m == 1 && fresh >= 0) m_owner[k][c] = fresh;
          else if (m_owner[k][c] < 0 || !cl[3-m_owner[k][c]]) m_owner[k][c] = held;
          if (m == 0) o = cl;
          else o = (m_owner[k][c] >= 0) ? (4'b1000 >> m_owner[k][c]) : 4'b0000;
          exp_dir[k][4*c +: 4] = o;
          exp_act[k][c] = (o != 4'b0000);
          m_prev[k][c] = cl;
          f = eff[0];
          if (!f || !m_pf[k][c]) begin
            m_afc[k][c] = 0; m_ph[k][c] = 1'b1;
          end else if (af_en[c] && ce) begin
            m_afc[k][c]++;
            if (m_afc[k][c] == AF) begin
              m_afc[k][c] = 0; m_ph[k][c] = !m_ph[k][c];
            end
          end
          exp_fire[k][c] = f && (af_en[c] ? m_ph[k][c] : 1'b1);
          m_pf[k][c] = f;
          m_inq[k][c] = {dir_in[4*c +: 4], fire_in[c]};
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input bit c);
    ce = c;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n, input bit c);
    for (int i = 0; i < n; i++) step(c);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    steps(2, 1'b0);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; dir_in = 8'hFF; fire_in = 2'b11;
    mode = 2'd0; socd = 1'b0; af_en = 2'b00;
    steps(2, 1'b0);
    n_tests++;
    if ({dout0, fout0, act0} !== 12'h000 || {dout4, fout4, act4} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: dut0=%h/%b/%b dut4=%h/%b/%b want 00/00/00",
               dout0, fout0, act0, dout4, fout4, act4);
    end
    reset_n = 1'b1;
    step(1'b0);
    n_tests++;
    if (dout0 !== 8'h00) begin
      n_fail++; $display("FAIL reset_latency1: dir_out=%h want 00", dout0);
    end
    step(1'b0);
    n_tests++;
    if (dout0 !== 8'hFF || fout0 !== 2'b11 || act0 !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: dir=%h fire=%b act=%b want ff/11/11", dout0, fout0, act0);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({dout0, fout0, act0} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: dir=%h fire=%b act=%b want 00/00/00", dout0, fout0, act0);
    end
    @(posedge clk); #1;
    dir_in = 8'h00; fire_in = 2'b00;
    reset_n = 1'b1;
    steps(2, 1'b0);
  endtask

  task automatic test_debounce();
    bit seen;
    dir_in = 8'h00; fire_in = 2'b00; mode = 2'd0; socd = 1'b0;
    do_reset();
    steps(4, 1'b0);
    seen = 1'b0;
    dir_in = 8'h08;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        step(i == 3);
        seen |= dout4[3];
      end
    end
    dir_in = 8'h00;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        step(i == 3);
        seen |= dout4[3];
      end
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL db_glitch: up seen=%b want 0", seen);
    end
    dir_in = 8'h08;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) step(i == 3);
    end
    n_tests++;
    if (dout4[3] !== 1'b0) begin
      n_fail++; $display("FAIL db_accept_edge: up=%b want 0", dout4[3]);
    end
    step(1'b0);
    n_tests++;
    if (dout4[3] !== 1'b1) begin
      n_fail++; $display("FAIL db_accept: up=%b want 1", dout4[3]);
    end
    dir_in = 8'h00;
    steps(20, 1'b1);
  endtask

  task automatic test_mode1();
    bit [3:0] pat [5] = '{4'b0001, 4'b1001, 4'b0001, 4'b0000, 4'b1010};
    bit [3:0] want[5] = '{4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b1000};
    mode = 2'd1; socd = 1'b0; dir_in = 8'h00;
    steps(2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dir_in = {4'h0, pat[i]};
      steps(2, 1'b0);
      n_tests++;
      if (dout0[3:0] !== want[i] || act0[0] !== (want[i] != 4'b0000)) begin
        n_fail++;
        $display("FAIL mode1_step%0d: dir=%b act=%b want %b", i, dout0[3:0], act0[0], want[i]);
      end
    end
    dir_in = 8'h00;
    steps(2, 1'b0);
  endtask

  task automatic test_mode2();
    mode = 2'd2; dir_in = 8'h00;
    steps(2, 1'b0);
    dir_in = 8'h02; steps(2, 1'b0);
    dir_in = 8'h0A; steps(2, 1'b0);
    n_tests++;
    if (dout0[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL mode2_hold: dir=%b want 0010", dout0[3:0]);
    end
    dir_in = 8'h08; steps(2, 1'b0);
    n_tests++;
    if (dout0[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL mode2_release: dir=%b want 1000", dout0[3:0]);
    end
    dir_in = 8'h02; steps(2, 1'b0);
    dir_in = 8'h0A; steps(2, 1'b0);
    mode = 2'd0; step(1'b0);
    n_tests++;
    if (dout0[3:0] !== 4'b1010) begin
      n_fail++; $display("FAIL mode_switch0: dir=%b want 1010", dout0[3:0]);
    end
    mode = 2'd2; step(1'b0);
    n_tests++;
    if (dout0[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL mode_rebuild: dir=%b want 1000", dout0[3:0]);
    end
    dir_in = 8'h00; mode = 2'd0;
    steps(2, 1'b0);
  endtask

  task automatic test_socd();
    mode = 2'd0; socd = 1'b1; dir_in = 8'h70;
    steps(2, 1'b0);
    n_tests++;
    if (dout0[7:4] !== 4'b0100 || act0[1] !== 1'b1) begin
      n_fail++; $display("FAIL socd_on: dir=%b act=%b want 0100/1", dout0[7:4], act0[1]);
    end
    socd = 1'b0; steps(2, 1'b0);
    n_tests++;
    if (dout0[7:4] !== 4'b0111) begin
      n_fail++; $display("FAIL socd_off: dir=%b want 0111", dout0[7:4]);
    end
    socd = 1'b1; dir_in = 8'hC0; steps(2, 1'b0);
    n_tests++;
    if (dout0[7:4] !== 4'b0000 || act0[1] !== 1'b0) begin
      n_fail++; $display("FAIL socd_ud: dir=%b act=%b want 0000/0", dout0[7:4], act0[1]);
    end
    socd = 1'b0; dir_in = 8'h00;
    steps(2, 1'b0);
  endtask

  task automatic test_autofire();
    bit want;
    mode = 2'd0; dir_in = 8'h00; fire_in = 2'b00; af_en = 2'b01;
    steps(3, 1'b1);
    fire_in = 2'b01;
    for (int s = 1; s <= 40; s++) begin
      step(1'b1);
      want = (s >= 2) ? (((s - 2) / 8) % 2 == 0) : 1'b0;
      n_tests++;
      if (fout0[0] !== want) begin
        n_fail++; $display("FAIL af_wave_s%0d: fire=%b want %b", s, fout0[0], want);
      end
    end
    fire_in = 2'b00;
    steps(2, 1'b1);
    n_tests++;
    if (fout0[0] !== 1'b0) begin
      n_fail++; $display("FAIL af_release: fire=%b want 0", fout0[0]);
    end
    af_en = 2'b00; fire_in = 2'b01;
    for (int s = 1; s <= 20; s++) begin
      step(1'b1);
      n_tests++;
      if (fout0[0] !== (s >= 2)) begin
        n_fail++; $display("FAIL af_off_s%0d: fire=%b want %b", s, fout0[0], (s >= 2));
      end
    end
    fire_in = 2'b00;
    steps(3, 1'b1);
  endtask

  task automatic test_random();
    int idx;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) reset_n = 1'b0;
      if (cyc == 703) reset_n = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 9);
        if (idx < 8) dir_in[idx] = ~dir_in[idx];
        else fire_in[idx - 8] = ~fire_in[idx - 8];
      end
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) socd = ~socd;
      if ($urandom_range(0, 99) == 0) af_en = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)));
      n_tests++;
      if ({dout0, fout0, act0} !== {exp_dir[0], exp_fire[0], exp_act[0]}) begin
        n_fail++;
        $display("FAIL rand_db0 cyc%0d: got %h/%b/%b want %h/%b/%b", cyc,
                 dout0, fout0, act0, exp_dir[0], exp_fire[0], exp_act[0]);
      end
      n_tests++;
      if ({dout4, fout4, act4} !== {exp_dir[1], exp_fire[1], exp_act[1]}) begin
        n_fail++;
        $display("FAIL rand_db4 cyc%0d: got %h/%b/%b want %h/%b/%b", cyc,
                 dout4, fout4, act4, exp_dir[1], exp_fire[1], exp_act[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mode1();
    test_mode2();
    test_socd();
    test_autofire();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/joy_dir_filter.md
Name: joy_dir_filter

Overview:
- Parametrised successor to the single-channel 4-way joystick restrictor.
- Per-channel processing, in order:
  - debounces raw direction and fire inputs;
  - optionally cleans opposing directions (SOCD);
  - applies one of three directional modes: 8-way pass, 4-way last-pressed, 4-way first-held;
  - adds per-channel autofire.
- Sits between the hps_io joystick words and the game core input-port mapping, in the clk_sys domain.

Parameters:
- NUM_CH, 2: number of joystick channels.
- DB_TICKS, 4: consecutive ce ticks an input must differ from its accepted value before the change is accepted. 0 bypasses debounce. Legal range 0..15.
- AF_DIV, 8: autofire half-period in ce ticks. Legal range 1..255.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ce, in, 1: timing tick for debounce and autofire, one clk wide.
- mode, in, 2: 0 = 8-way pass; 1 = 4-way last-pressed; 2 = 4-way first-held; 3 = treated as 1.
- socd, in, 1: 1 = opposing-direction cleaning enabled.
- af_en, in, NUM_CH: per-channel autofire enable.
- dir_in, in, 4*NUM_CH: per channel {up,down,left,right}; channel c occupies [4c+3:4c].
- fire_in, in, NUM_CH: raw fire per channel.
- dir_out, out, 4*NUM_CH: filtered directions, same packing as dir_in.
- fire_out, out, NUM_CH: filtered fire.
- active, out, NUM_CH: channel c has any dir_out bit set.

Behaviour:
- Reset (async, reset_n=0):
  - dir_out, fire_out, active = 0.
  - Debounced values, debounce counters, mask and autofire counters = 0; autofire phase = 1.
- Stage 0: dir_in/fire_in registered every clk into in_q.
- Debounce, one 4-bit counter per input bit:
  - On a ce tick with in_q == deb: counter := 0.
  - On a ce tick with in_q != deb: counter +1. On the tick where it would reach DB_TICKS, deb := in_q and counter := 0.
  - A glitch shorter than DB_TICKS ticks is never accepted.
  - DB_TICKS = 0: deb := in_q every clk.
- SOCD (combinational on deb): if socd=1, up&down both set → both cleared; left&right both set → both cleared. Result is cl.
- Direction mask, 4-bit, one-hot or zero, updated each clk:
  - mode 0: mask := 0 and dir_out := cl (diagonals pass).
  - mode 1:
    - new = cl & ~cl_prev.
    - If new ≠ 0, mask := highest-priority new bit. Priority: up > down > left > right.
    - Else if (cl & mask) == 0, mask := highest-priority bit of cl, or 0 if cl = 0. This is fallback to a still-held direction.
  - mode 2: mask is replaced only when (cl & mask) == 0, by the highest-priority bit of cl. New presses are ignored while the masked direction is held.
  - modes 1/2: dir_out := cl & mask.
  - A mode change takes effect the next clk. The mask is rebuilt from cl by the fallback rule; no stale mask survives a switch through mode 0.
- Autofire, per channel: 8-bit counter plus phase bit.
  - Rising edge of debounced fire: counter := 0, phase := 1.
  - While fire held, af_en=1 and ce: counter +1; at AF_DIV-1, counter := 0 and phase toggles.
  - Fire released: counter := 0, phase := 1.
  - fire_out := deb_fire & (af_en ? phase : 1).
  - Changing af_en mid-hold does not reset phase.
- Latency with DB_TICKS=0: 2 clk from dir_in/fire_in to dir_out/fire_out (in_q, output register).
- Latency with DB_TICKS=N: acceptance on the Nth ce tick after in_q changes, +1 clk to output.
- active registered alongside dir_out, same cycle.
- Channels are fully independent; simultaneous presses on different channels do not interact.
- reset_n deassertion mid-hold: inputs are re-debounced from 0 and treated as new presses.

Test Plan:
- Reset: reset_n=0 with dir_in=all 1s → dir_out=0, fire_out=0, active=0 asynchronously. Release with DB_TICKS=0, mode 0, socd=0 → dir_out=all 1s 2 clk later.
- Debounce (DB_TICKS=4, ce every 4 clk): ch0 up pulse lasting 3 ticks → dir_out[3]=0 throughout. Hold 4 ticks → dir_out[3]=1 one clk after the 4th tick.
- Mode 1, ch0:
  - press right, then up while right held → dir_out[3:0]=4'b1000.
  - release up → 4'b0001 (fallback).
  - release right → 4'b0000.
  - up+left pressed same clk → 4'b1000.
- Mode 2, ch0: hold left, press up → dir_out[3:0] stays 4'b0010. Release left → 4'b1000.
- SOCD: socd=1, mode 0, ch1 left+right+down → dir_out[7:4]=4'b0100. socd=0 → 4'b0111.
- Autofire: AF_DIV=8, af_en[0]=1, ce every clk, fire_in[0] held 40 clk → fire_out[0] high immediately for 8 ticks, then low 8, high 8 (square wave). Release → 0. af_en[0]=0 → steady 1 while held.
